// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the 5-stage RV32I pipeline control logic.
//   - fwd_sel_e   : EX operand source select driven by the forwarding units
//   - mdu_state_e : states of the multi-cycle MUL/DIV hold sequencer
//   - reg_hit()   : "a later stage writes the register this operand reads"
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // x0 is hard-wired to zero, so a write to it never produces a value
    // worth forwarding.
    function automatic logic reg_hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
//   Combinational operand-forwarding select for one EX source operand.
//   Ports:
//     rs_e         in  5  source register read by the instruction in E
//     rd_m         in  5  destination register of the instruction in M
//     reg_write_m  in  1  instruction in M writes rd_m
//     rd_w         in  5  destination register of the instruction in W
//     reg_write_w  in  1  instruction in W writes rd_w
//     fwd_sel      out 2  00 register file, 01 W result, 10 M result
// -----------------------------------------------------------------------------
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    fwd_sel_e sel;

    // M holds the younger result, so it wins over W when both match.
    always_comb begin
        sel = FWD_RF;
        if (reg_hit(reg_write_m, rd_m, rs_e)) begin
            sel = FWD_MEM;
        end else if (reg_hit(reg_write_w, rd_w, rs_e)) begin
            sel = FWD_WB;
        end
    end

    assign fwd_sel = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV32I core: stall/flush
//   enables for the PC, F/D, D/E and E/M registers, EX forwarding selects,
//   a MUL/DIV hold sequencer and saturating performance counters.
//   Parameters:
//     MDU_LATENCY  stall cycles imposed by a multi-cycle MDU op (>= 2)
//     CNT_W        width of the performance counters
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     rs1_d, rs2_d                sources of the instruction in D
//     rs1_e, rs2_e, rd_e          sources/destination of the instruction in E
//     load_e, mdu_start_e         E holds a load / a multi-cycle MUL/DIV
//     pc_src_e                    taken branch or jump resolved in E
//     rd_m, reg_write_m           destination/write enable in M
//     rd_w, reg_write_w           destination/write enable in W
//     imem_ready                  instruction fetch completes this cycle
//     stall_f, stall_d, stall_e   hold PC, F/D, D/E
//     flush_d, flush_e, flush_m   bubble into F/D, D/E, E/M
//     forward_a_e, forward_b_e    EX operand selects
//     mdu_busy, mdu_done          sequencer not idle / MDU result valid
//     stall_count, flush_count    saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LATENCY = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             mdu_start_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    input  logic             imem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Countdown only needs to hold MDU_LATENCY-2.
    localparam int LAT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

    mdu_state_e             state_q, state_d;
    logic [LAT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;
    logic [CNT_W-1:0]       flush_count_q, flush_count_d;

    logic                   run;
    logic                   lw_stall;
    logic                   mdu_stall;
    logic [1:0]             fwd_a_raw;
    logic [1:0]             fwd_b_raw;

    // Every control output must read zero while reset is held, including
    // the purely combinational ones, so everything is qualified with run.
    assign run = ~reset;

    // ---------------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------------
    forward_unit u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a_raw)
    );

    forward_unit u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b_raw)
    );

    assign forward_a_e = run ? fwd_a_raw : FWD_RF;
    assign forward_b_e = run ? fwd_b_raw : FWD_RF;

    // ---------------------------------------------------------------------
    // Stall / flush
    // ---------------------------------------------------------------------
    assign lw_stall = run & load_e & (rd_e != 5'd0)
                    & ((rd_e == rs1_d) | (rd_e == rs2_d));

    // Mealy on mdu_start_e so the hold begins in the op's first E cycle;
    // together with the BUSY cycles this gives exactly MDU_LATENCY stalls.
    assign mdu_stall = run & (((state_q == IDLE) & mdu_start_e)
                              | (state_q == BUSY));

    // A redirect overrides a pending fetch: the PC takes the target and
    // the stale fetch is discarded. A fetch wait under a stall holds F/D
    // instead of bubbling it, since D still carries a live instruction.
    assign stall_f = lw_stall | mdu_stall | (run & ~imem_ready & ~pc_src_e);
    assign stall_d = lw_stall | mdu_stall;
    assign stall_e = mdu_stall;
    assign flush_d = run & (pc_src_e | (~imem_ready & ~lw_stall & ~mdu_stall));
    assign flush_e = (run & pc_src_e) | lw_stall;
    assign flush_m = mdu_stall;

    assign mdu_busy = run & (state_q != IDLE);
    assign mdu_done = run & (state_q == DONE);

    // ---------------------------------------------------------------------
    // MDU hold sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_start_e) begin
                    state_d = BUSY;
                    cnt_d   = LAT_W'(MDU_LATENCY - 2);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            // mdu_start_e still reflects the finishing op here; it must not
            // relaunch the sequencer.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_f && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (run && pc_src_e && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int L    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, mdu_start_e, pc_src_e, reg_write_m, reg_write_w, imem_ready;
    logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done;
    logic [1:0]    forward_a_e, forward_b_e;
    logic [CW-1:0] stall_count, flush_count;

    int n_vec = 0;
    int n_err = 0;

    // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done}
    logic [7:0] ctl;
    assign ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done};

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .mdu_start_e(mdu_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .imem_ready(imem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        load_e = 0; mdu_start_e = 0; pc_src_e = 0;
        reg_write_m = 0; reg_write_w = 0; imem_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        mdu_start_e = 1; imem_ready = 0;
        reg_write_m = 1; rd_m = 5; rs1_e = 5; rs2_e = 5;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL reset_ctl got %b expected %b", ctl, 8'h00); end
        n_vec++; if ({forward_a_e, forward_b_e} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd got %b expected 0000", {forward_a_e, forward_b_e}); end
        n_vec++; if ({stall_count, flush_count} !== '0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", stall_count, flush_count); end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        do_reset();
        reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 5;
        #1;
        n_vec++; if (forward_a_e !== 2'b10) begin n_err++; $display("FAIL fwd_m_prio got %b expected 10", forward_a_e); end
        n_vec++; if (forward_b_e !== 2'b10) begin n_err++; $display("FAIL fwd_b_m got %b expected 10", forward_b_e); end
        reg_write_m = 0;
        #1;
        n_vec++; if (forward_a_e !== 2'b01) begin n_err++; $display("FAIL fwd_w got %b expected 01", forward_a_e); end
        reg_write_m = 1; rd_m = 0; rs1_e = 0; rd_w = 0;
        #1;
        n_vec++; if (forward_a_e !== 2'b00) begin n_err++; $display("FAIL fwd_x0 got %b expected 00", forward_a_e); end
        rd_m = 9; rd_w = 6; rs2_e = 6;
        #1;
        n_vec++; if (forward_b_e !== 2'b01) begin n_err++; $display("FAIL fwd_b_w got %b expected 01", forward_b_e); end
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL fwd_no_stall got %b expected 00000000", ctl); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 3;
        #1;
        n_vec++; if (ctl !== 8'b1100_1000) begin n_err++; $display("FAIL lw_ctl got %b expected 11001000", ctl); end
        @(negedge clk);
        load_e = 0;
        #1;
        n_vec++; if (stall_count !== 4'd1) begin n_err++; $display("FAIL lw_cnt got %0d expected 1", stall_count); end
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL lw_one_cycle got %b expected 00000000", ctl); end
        load_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
        #1;
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL lw_x0 got %b expected 00000000", ctl); end
    endtask

    task automatic test_mdu();
        logic [7:0] exp;
        do_reset();
        mdu_start_e = 1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) mdu_start_e = 0;
            #1;
            if (c == 1)      exp = 8'b1110_0100;
            else if (c <= L) exp = 8'b1110_0110;
            else if (c == L + 1) exp = 8'b0000_0011;
            else             exp = 8'b0000_0000;
            n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL mdu_cycle%0d got %b expected %b", c, ctl, exp); end
            @(negedge clk);
        end
        n_vec++; if (stall_count !== 4'(L)) begin n_err++; $display("FAIL mdu_cnt got %0d expected %0d", stall_count, L); end
    endtask

    task automatic test_branch_fetch_wait();
        do_reset();
        imem_ready = 0; pc_src_e = 1;
        #1;
        n_vec++; if (ctl !== 8'b0001_1000) begin n_err++; $display("FAIL br_wait_ctl got %b expected 00011000", ctl); end
        @(negedge clk);
        pc_src_e = 0;
        #1;
        n_vec++; if ({stall_count, flush_count} !== {4'd0, 4'd1}) begin n_err++; $display("FAIL br_cnt got %0d/%0d expected 0/1", stall_count, flush_count); end
        n_vec++; if (ctl !== 8'b1001_0000) begin n_err++; $display("FAIL fetch_wait got %b expected 10010000", ctl); end
    endtask

    task automatic test_lw_fetch_wait();
        do_reset();
        imem_ready = 0; load_e = 1; rd_e = 3; rs1_d = 3;
        #1;
        n_vec++; if (ctl !== 8'b1100_1000) begin n_err++; $display("FAIL lw_fetch_wait got %b expected 11001000", ctl); end
        load_e = 0; mdu_start_e = 1;
        #1;
        n_vec++; if (ctl !== 8'b1110_0100) begin n_err++; $display("FAIL mdu_fetch_wait got %b expected 11100100", ctl); end
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        imem_ready = 1; mdu_start_e = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (ctl !== 8'b1110_0110) begin n_err++; $display("FAIL pre_rst_busy got %b expected 11100110", ctl); end
        reset = 1'b1;
        #1;
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rst_mid_ctl got %b expected 00000000", ctl); end
        n_vec++; if ({stall_count, flush_count} !== '0) begin n_err++; $display("FAIL rst_mid_cnt got %0d/%0d expected 0/0", stall_count, flush_count); end
        @(negedge clk);
        mdu_start_e = 0;
        reset = 1'b0;
        #1;
        n_vec++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rst_release_idle got %b expected 00000000", ctl); end
        @(negedge clk);
        #1;
        n_vec++; if ({stall_count, flush_count, mdu_busy} !== '0) begin n_err++; $display("FAIL rst_release_cnt got %0d/%0d busy %b expected 0/0 0", stall_count, flush_count, mdu_busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        imem_ready = 0;
        repeat (CMAX + 5) @(negedge clk);
        #1;
        n_vec++; if (stall_count !== 4'(CMAX)) begin n_err++; $display("FAIL sat_stall got %0d expected %0d", stall_count, CMAX); end
        imem_ready = 1; pc_src_e = 1;
        repeat (CMAX + 5) @(negedge clk);
        #1;
        n_vec++; if (flush_count !== 4'(CMAX)) begin n_err++; $display("FAIL sat_flush got %0d expected %0d", flush_count, CMAX); end
        n_vec++; if (stall_count !== 4'(CMAX)) begin n_err++; $display("FAIL sat_stall_hold got %0d expected %0d", stall_count, CMAX); end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: track how many cycles the current MDU op has spent in E.
    task automatic test_random();
        int age = 0;
        int m_stall_cnt = 0;
        int m_flush_cnt = 0;
        int kind;
        logic lw, ms, sf, sd, se, fd, fe, fm, busy, done;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            imem_ready = ($urandom_range(0, 3) != 0);
            load_e = 0; pc_src_e = 0; mdu_start_e = 0;
            if (age > 0) begin
                mdu_start_e = 1;
            end else begin
                kind = $urandom_range(0, 9);
                if (kind == 0) mdu_start_e = 1;
                else if (kind <= 3) load_e = 1;
                else if (kind <= 5) pc_src_e = 1;
            end
            lw   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
            busy = (age != 0);
            ms   = (!busy && mdu_start_e) || (busy && age < L);
            done = busy && age == L;
            sf = lw | ms | (!imem_ready & !pc_src_e);
            sd = lw | ms;
            se = ms;
            fd = pc_src_e | (!imem_ready & !lw & !ms);
            fe = pc_src_e | lw;
            fm = ms;
            #2;
            n_vec++; if (ctl !== {sf, sd, se, fd, fe, fm, busy, done}) begin n_err++; $display("FAIL rand_ctl cyc %0d got %b expected %b", cyc, ctl, {sf, sd, se, fd, fe, fm, busy, done}); end
            n_vec++; if (forward_a_e !== ref_fwd(rs1_e)) begin n_err++; $display("FAIL rand_fwd_a cyc %0d got %b expected %b", cyc, forward_a_e, ref_fwd(rs1_e)); end
            n_vec++; if (forward_b_e !== ref_fwd(rs2_e)) begin n_err++; $display("FAIL rand_fwd_b cyc %0d got %b expected %b", cyc, forward_b_e, ref_fwd(rs2_e)); end
            n_vec++; if (stall_count !== 4'(m_stall_cnt)) begin n_err++; $display("FAIL rand_stall_cnt cyc %0d got %0d expected %0d", cyc, stall_count, m_stall_cnt); end
            n_vec++; if (flush_count !== 4'(m_flush_cnt)) begin n_err++; $display("FAIL rand_flush_cnt cyc %0d got %0d expected %0d", cyc, flush_count, m_flush_cnt); end
            if (sf && m_stall_cnt < CMAX) m_stall_cnt++;
            if (pc_src_e && m_flush_cnt < CMAX) m_flush_cnt++;
            if (!busy) age = mdu_start_e ? 1 : 0;
            else       age = (age == L) ? 0 : age + 1;
            @(negedge clk);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_branch_fetch_wait();
        test_lw_fetch_wait();
        test_reset_mid_mdu();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives stall and flush enables into the F/D, D/E and E/M pipeline registers, and it generates the EX-stage operand forwarding selects. It also runs a small state machine that holds the pipeline for multi-cycle MUL/DIV operations, and it keeps saturating stall and redirect counters for performance reporting.

## Interface
Parameters:
- MDU_LATENCY, 8, number of stall cycles a multi-cycle MDU op imposes; must be ≥ 2
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs1_d, rs2_d  in  5  source registers of the instruction in D
- rs1_e, rs2_e, rd_e  in  5  source and destination registers of the instruction in E
- load_e  in  1  instruction in E is a load
- mdu_start_e  in  1  instruction in E is a multi-cycle MUL/DIV
- pc_src_e  in  1  taken branch or jump resolved in E
- rd_m, reg_write_m  in  5, 1  destination register and write enable of the instruction in M
- rd_w, reg_write_w  in  5, 1  destination register and write enable of the instruction in W
- imem_ready  in  1  instruction memory returns a valid fetch this cycle
- stall_f, stall_d, stall_e  out  1  hold the PC, F/D and D/E registers
- flush_d, flush_e, flush_m  out  1  load a bubble into F/D, D/E and E/M
- forward_a_e, forward_b_e  out  2  EX operand select: 00 register file, 01 W result, 10 M result
- mdu_busy  out  1  MDU FSM is not IDLE
- mdu_done  out  1  MDU result valid; the op leaves E at the next edge
- stall_count, flush_count  out  CNT_W  performance counters

## Operation
- Forwarding (per operand, shown for A):
  - 10 when reg_write_m, rd_m≠0 and rd_m==rs1_e.
  - Otherwise 01 when reg_write_w, rd_w≠0 and rd_w==rs1_e.
  - Otherwise 00.
  - M has priority over W.
- Load-use stall: lw_stall = load_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d).
- MDU FSM states:
  - IDLE: when mdu_start_e is seen, load cnt=MDU_LATENCY−2 and go to BUSY.
  - BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: assert mdu_done and return to IDLE unconditionally. mdu_start_e is ignored in DONE, because the same op is still in E.
- mdu_stall = (IDLE & mdu_start_e) | BUSY. This is Mealy, so the stall starts in the first cycle the op sits in E.
- Output equations:
  - stall_f = lw_stall | mdu_stall | (~imem_ready & ~pc_src_e)
  - stall_d = lw_stall | mdu_stall
  - stall_e = mdu_stall
  - flush_d = pc_src_e | (~imem_ready & ~lw_stall & ~mdu_stall)
  - flush_e = pc_src_e | lw_stall
  - flush_m = mdu_stall
- Counters:
  - stall_count increments in every cycle with stall_f=1.
  - flush_count increments in every cycle with pc_src_e=1.
  - Both saturate at all-ones.
- Precondition: pc_src_e, load_e and mdu_start_e are mutually exclusive (single E slot). The behaviour when two of them are asserted together is undefined, and the bench does not drive that combination.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, with zero latency.
- An MDU op occupies E for MDU_LATENCY+1 cycles:
  - stall_e is high for exactly MDU_LATENCY of them.
  - mdu_done is high for the final cycle.
- When imem_ready=0 and pc_src_e=1 in the same cycle, the PC loads the branch target (stall_f=0) and the in-flight fetch is discarded (flush_d=1).
- When imem_ready=0 coincides with lw_stall or mdu_stall, F/D holds (flush_d=0).
- Reset:
  - While reset is high, every stall, flush and mdu_* output is 0.
  - forward_a_e and forward_b_e are 00.
  - The FSM is in IDLE with cnt=0, and both counters are 0.
  - Reset asserted mid-MDU abandons the op immediately.

## Structure
- Shared package pipe_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mdu_state_e enum: IDLE, BUSY, DONE.
- Sub-module forward_unit (combinational) is instantiated twice, once per operand. The FSM, stall/flush logic and counters stay in hazard_ctrl.

## Test plan
- Forwarding:
  - reg_write_m=1, rd_m=5, reg_write_w=1, rd_w=5, rs1_e=5 → forward_a_e=10.
  - Drop reg_write_m → forward_a_e=01.
  - rd_m=0, rs1_e=0 → 00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for one cycle; stall_count goes 0→1. With rd_e=0 → no stall.
- MDU with MDU_LATENCY=4: pulse-hold mdu_start_e → stall_e high for 4 cycles, flush_m high for 4 cycles, mdu_done high in cycle 5, mdu_busy high in cycles 2–5, FSM back to IDLE in cycle 6.
- Branch redirect during fetch wait: pc_src_e=1, imem_ready=0 → stall_f=0, flush_d=flush_e=1; flush_count increments.
- Fetch wait under lw_stall: imem_ready=0 with lw_stall=1 → flush_d=0, stall_d=1.
- Reset mid-MDU: assert reset in the second BUSY cycle → all outputs 0 asynchronously. After release with mdu_start_e=0, the FSM is in IDLE and the counters are 0.
